// File: rtl/fetch_row_unpacker_pkg.sv
// Shared widths and tile geometry for the fetch path (fetch stage, unpacker, compute array).
// Helper keeps counter widths at least one bit for degenerate parameter choices.
package fetch_row_unpacker_pkg;

    localparam int DATA_W     = 256;
    localparam int OUT_W      = 64;
    localparam int BEATS      = DATA_W / OUT_W;
    localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TILE_ROWS  = 32;
    localparam int DEPTH      = 4;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/fetch_row_unpacker_row_fifo.sv
// Synchronous DEPTH x DATA_W register FIFO with flush, occupancy level and head-of-queue output.
// Storage is cleared only by reset so the head output reads zero out of reset.
module row_fifo
    import fetch_row_unpacker_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    // Guard against caller misuse so pointers and level can never diverge.
    assign push_ok = push && (level_q != LVL_W'(DEPTH));
    assign pop_ok  = pop && (level_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

endmodule

// File: rtl/fetch_row_unpacker.sv
// Buffers BRAM rows and serializes each into OUT_W beats, tracking tile boundaries.
// Flags rows dropped while the buffer is full (sticky until reset or flush).
module fetch_row_unpacker
    import fetch_row_unpacker_pkg::*;
#(
    parameter int DATA_W    = fetch_row_unpacker_pkg::DATA_W,
    parameter int OUT_W     = fetch_row_unpacker_pkg::OUT_W,
    parameter int DEPTH     = fetch_row_unpacker_pkg::DEPTH,
    parameter int TILE_ROWS = fetch_row_unpacker_pkg::TILE_ROWS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       tile_done,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int NBEATS = DATA_W / OUT_W;
    localparam int BEAT_W = clog2_min1(NBEATS);
    localparam int ROW_W  = clog2_min1(TILE_ROWS);
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] head_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              push;
    logic              pop;
    logic              beat_hs;
    logic              beat_last;
    logic              row_last;

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              overflow_q, overflow_d;
    logic              tile_done_q, tile_done_d;

    assign in_ready  = (fifo_level < LVL_W'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign beat_hs   = out_valid && out_ready;
    assign beat_last = (beat_q == BEAT_W'(NBEATS - 1));
    assign row_last  = (row_q == ROW_W'(TILE_ROWS - 1));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = beat_hs && beat_last && !flush;

    row_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .wr_data   (in_data),
        .head_data (head_data),
        .level     (fifo_level)
    );

    always_comb begin
        beat_d      = beat_q;
        row_d       = row_q;
        overflow_d  = overflow_q;
        tile_done_d = 1'b0;
        if (flush) begin
            beat_d     = '0;
            row_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow_d = 1'b1;
            end
            if (beat_hs) begin
                if (beat_last) begin
                    beat_d      = '0;
                    row_d       = row_last ? '0 : row_q + 1'b1;
                    tile_done_d = row_last;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            row_q       <= '0;
            overflow_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            row_q       <= row_d;
            overflow_q  <= overflow_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Beat select depends only on stored row and beat counter, so it holds steady under stall.
    assign out_data  = head_data[beat_q*OUT_W +: OUT_W];
    assign out_last  = out_valid && beat_last && row_last;
    assign tile_done = tile_done_q;
    assign overflow  = overflow_q;
    assign level     = fifo_level;

endmodule

// File: tb/tb_fetch_row_unpacker.sv
// Directed bench for fetch_row_unpacker: reset, streaming tile, overflow, level-3 push/pop,
// stalls, flush and mid-row reset, with expectations built from the row pattern below.
module tb_fetch_row_unpacker;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [255:0] in_data;
    logic         in_ready;
    logic         flush;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         out_ready;
    logic         out_last;
    logic         tile_done;
    logic         overflow;
    logic [2:0]   level;

    int errors = 0;
    int checks = 0;

    fetch_row_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .tile_done (tile_done),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word i of row r is r*256+i, so every beat of every row is distinct.
    function automatic logic [255:0] make_row(input int r);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(r * 256 + i);
        return v;
    endfunction

    function automatic logic [63:0] beat_of(input int r, input int k);
        logic [255:0] v;
        v = make_row(r);
        return v[k*64 +: 64];
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1'b1));
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(1'b0));
        chk({tag, "_out_data"}, 256'(out_data), 256'(64'h0));
        chk({tag, "_out_last"}, 256'(out_last), 256'(1'b0));
        chk({tag, "_tile_done"}, 256'(tile_done), 256'(1'b0));
        chk({tag, "_overflow"}, 256'(overflow), 256'(1'b0));
        chk({tag, "_level"}, 256'(level), 256'(3'd0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Streams rows 0..31 at one row per 4 cycles with out_ready high; checks every beat.
    task automatic run_tile(input string tag, input int last_c);
        out_ready = 1'b1;
        for (int c = 0; c <= last_c; c++) begin
            in_valid = (c % 4 == 0) && (c < 128);
            in_data  = make_row(c / 4);
            tick();
            in_valid = 1'b0;
            if (c < 128) begin
                chk({tag, "_valid"}, 256'(out_valid), 256'(1'b1));
                chk({tag, "_data"}, 256'(out_data), 256'(beat_of(c / 4, c % 4)));
                chk({tag, "_last"}, 256'(out_last), 256'(c == 127));
                chk({tag, "_tdone"}, 256'(tile_done), 256'(1'b0));
                chk({tag, "_ovf"}, 256'(overflow), 256'(1'b0));
            end else if (c == 128) begin
                chk({tag, "_drained"}, 256'(out_valid), 256'(1'b0));
                chk({tag, "_tdone_pulse"}, 256'(tile_done), 256'(1'b1));
            end else begin
                chk({tag, "_tdone_end"}, 256'(tile_done), 256'(1'b0));
            end
        end
    endtask

    logic [255:0] row_a;
    logic [63:0]  t1_exp [4];
    int           bi;

    initial begin
        in_data  = '0;
        t1_exp[0] = 64'h0000_0004_0000_0002;
        t1_exp[1] = 64'h0000_0008_0000_0006;
        t1_exp[2] = 64'h0000_000C_0000_000A;
        t1_exp[3] = 64'h0000_0010_0000_000E;
        for (int i = 0; i < 8; i++) row_a[i*32 +: 32] = 32'(2 * i + 2);

        // Reset values
        do_reset();
        check_reset_values("rst");

        // Single row, consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = row_a;
        tick();
        in_valid = 1'b0;
        chk("t1_level1", 256'(level), 256'(3'd1));
        for (int k = 0; k < 4; k++) begin
            chk("t1_beat", 256'(out_data), 256'(t1_exp[k]));
            tick();
        end
        chk("t1_level0", 256'(level), 256'(3'd0));

        // Full tile, out_last on beat 128, tile_done the cycle after
        do_reset();
        run_tile("t2", 129);

        // Overflow with consumer stalled, then drain rows 1..4
        do_reset();
        for (int r = 1; r <= 5; r++) begin
            chk("t3_in_ready", 256'(in_ready), 256'(r <= 4));
            in_valid = 1'b1;
            in_data  = make_row(r);
            tick();
        end
        in_valid = 1'b0;
        chk("t3_level4", 256'(level), 256'(3'd4));
        chk("t3_overflow", 256'(overflow), 256'(1'b1));
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            chk("t3_drain_valid", 256'(out_valid), 256'(1'b1));
            chk("t3_drain_data", 256'(out_data), 256'(beat_of(1 + c / 4, c % 4)));
            tick();
        end
        chk("t3_empty", 256'(out_valid), 256'(1'b0));
        chk("t3_ovf_sticky", 256'(overflow), 256'(1'b1));

        // Push coinciding with final-beat pop at level 3
        do_reset();
        for (int r = 10; r <= 12; r++) begin
            in_valid = 1'b1;
            in_data  = make_row(r);
            tick();
        end
        in_valid = 1'b0;
        chk("t4_level3", 256'(level), 256'(3'd3));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_row10", 256'(out_data), 256'(beat_of(10, k)));
            tick();
        end
        chk("t4_row10_b3", 256'(out_data), 256'(beat_of(10, 3)));
        chk("t4_in_ready", 256'(in_ready), 256'(1'b1));
        in_valid = 1'b1;
        in_data  = make_row(13);
        tick();
        in_valid = 1'b0;
        chk("t4_level_kept", 256'(level), 256'(3'd3));
        for (int c = 0; c < 12; c++) begin
            chk("t4_drain", 256'(out_data), 256'(beat_of(11 + c / 4, c % 4)));
            tick();
        end
        chk("t4_level0", 256'(level), 256'(3'd0));
        chk("t4_no_ovf", 256'(overflow), 256'(1'b0));

        // Consumer toggling ready every cycle
        do_reset();
        in_valid = 1'b1;
        in_data  = make_row(20);
        tick();
        in_valid = 1'b0;
        bi = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c % 2 == 1);
            chk("t5_stall_data", 256'(out_data), 256'(beat_of(20, bi)));
            tick();
            if (c % 2 == 1) bi++;
        end
        chk("t5_level0", 256'(level), 256'(3'd0));

        // Flush at beat 2 of row 10 (with a discarded push), full tile, reset mid-row, full tile
        do_reset();
        run_tile("t6a", 42);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = make_row(99);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t6_flush_level", 256'(level), 256'(3'd0));
        chk("t6_flush_valid", 256'(out_valid), 256'(1'b0));
        chk("t6_flush_tdone", 256'(tile_done), 256'(1'b0));
        run_tile("t6b", 129);
        in_valid = 1'b1;
        in_data  = make_row(50);
        tick();
        in_valid = 1'b0;
        chk("t6_r50_b0", 256'(out_data), 256'(beat_of(50, 0)));
        tick();
        chk("t6_r50_b1", 256'(out_data), 256'(beat_of(50, 1)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        check_reset_values("t6_rst");
        run_tile("t6c", 129);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
